// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: SPI byte-stream and register-bank signals of spi_cmd_ctrl.
// slave modport is the command controller; master is the SPI core / bank side.
interface spi_cmd_ctrl_if;
    logic       ssel;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       idle_flag;

    modport slave (
        input  ssel, rx_valid, rx_data, reg_rdata,
        output tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, idle_flag
    );

    modport master (
        output ssel, rx_valid, rx_data, reg_rdata,
        input  tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, idle_flag
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: parses 6-byte SD-style command frames from an SPI byte stream,
// executes register read/write and returns R1 (+ data byte on reads) after
// NCR_BYTES fill slots. Optional CRC7 frame check: define SPI_CMD_CRC_EN.
module spi_cmd_ctrl #(
    parameter int unsigned NCR_BYTES = 1
) (
    input  logic          clk,
    input  logic          rst,
    spi_cmd_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARG   = 3'd1;
    localparam logic [2:0] S_CRC   = 3'd2;
    localparam logic [2:0] S_EXEC1 = 3'd3;
    localparam logic [2:0] S_EXEC2 = 3'd4;
    localparam logic [2:0] S_NCR   = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;
    localparam logic [2:0] S_DATA  = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic [7:0]       arg_addr_q, arg_addr_d;
    logic [7:0]       arg_data_q, arg_data_d;
    logic [7:0]       r1_q, r1_d;
    logic             read_q, read_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             idle_q, idle_d;
    logic             rd_lat_q;
    logic [7:0]       rdata_q;
    logic             legal_c;
    logic             crc_ok_c;

`ifdef SPI_CMD_CRC_EN
    logic [6:0] crc_q, crc_d;
    logic [7:0] crc_byte_q, crc_byte_d;

    // CRC7 (x^7+x^3+1) advanced by one byte, MSB first
    function automatic logic [6:0] crc7_upd(input logic [6:0] c_in, input logic [7:0] d);
        logic [6:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc_ok_c = (crc_byte_q[7:1] == crc_q) && crc_byte_q[0];
`else
    assign crc_ok_c = 1'b1;
`endif

    // Frame sequencing, command decode and slot byte selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        arg_addr_d = arg_addr_q;
        arg_data_d = arg_data_q;
        r1_d       = r1_q;
        read_d     = read_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        idle_d     = idle_q;
        legal_c    = (idx_q == 6'd0) || (idx_q == 6'd1) || (idx_q == 6'd17) || (idx_q == 6'd24);
`ifdef SPI_CMD_CRC_EN
        crc_d      = crc_q;
        crc_byte_d = crc_byte_q;
`endif
        if (bus.ssel) begin
            state_d = S_IDLE;
            tx_d    = 8'hFF;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_d = 8'hFF;
                    if (bus.rx_valid && (bus.rx_data[7:6] == 2'b01)) begin
                        idx_d   = bus.rx_data[5:0];
                        cnt_d   = '0;
                        state_d = S_ARG;
`ifdef SPI_CMD_CRC_EN
                        crc_d   = crc7_upd(7'h00, bus.rx_data);
`endif
                    end
                end
                S_ARG: begin
                    if (bus.rx_valid) begin
                        if (cnt_q == CNT_W'(0)) arg_addr_d = bus.rx_data;
                        if (cnt_q == CNT_W'(3)) arg_data_d = bus.rx_data;
`ifdef SPI_CMD_CRC_EN
                        crc_d = crc7_upd(crc_q, bus.rx_data);
`endif
                        if (cnt_q == CNT_W'(3)) state_d = S_CRC;
                        else                    cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                S_CRC: begin
                    if (bus.rx_valid) begin
`ifdef SPI_CMD_CRC_EN
                        crc_byte_d = bus.rx_data;
`endif
                        state_d = S_EXEC1;
                    end
                end
                S_EXEC1: begin
                    read_d  = 1'b0;
                    state_d = S_EXEC2;
                    if (crc_ok_c) begin
                        case (idx_q)
                            6'd0:  idle_d = 1'b1;
                            6'd1:  idle_d = 1'b0;
                            6'd17: begin
                                rd_d   = 1'b1;
                                read_d = 1'b1;
                                addr_d = arg_addr_q;
                            end
                            6'd24: begin
                                wr_d    = 1'b1;
                                addr_d  = arg_addr_q;
                                wdata_d = arg_data_q;
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC2: begin
                    r1_d    = {4'b0, ~crc_ok_c, crc_ok_c & ~legal_c, 1'b0, idle_q};
                    cnt_d   = '0;
                    state_d = S_NCR;
                end
                S_NCR: begin
                    if (bus.rx_valid) begin
                        if (cnt_q == CNT_W'(NCR_BYTES - 1)) begin
                            tx_d    = r1_q;
                            state_d = S_RESP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rx_valid) begin
                        if (read_q) begin
                            tx_d    = rdata_q;
                            state_d = S_DATA;
                        end else begin
                            tx_d    = 8'hFF;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        tx_d    = 8'hFF;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    tx_d    = 8'hFF;
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            arg_addr_q <= '0;
            arg_data_q <= '0;
            r1_q       <= '0;
            read_q     <= 1'b0;
            tx_q       <= 8'hFF;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b1;
`ifdef SPI_CMD_CRC_EN
            crc_q      <= '0;
            crc_byte_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            arg_addr_q <= arg_addr_d;
            arg_data_q <= arg_data_d;
            r1_q       <= r1_d;
            read_q     <= read_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            idle_q     <= idle_d;
`ifdef SPI_CMD_CRC_EN
            crc_q      <= crc_d;
            crc_byte_q <= crc_byte_d;
`endif
        end
    end

    // Capture read data the clock after the read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lat_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_lat_q <= rd_q;
            if (rd_lat_q) rdata_q <= bus.reg_rdata;
        end
    end

    assign bus.tx_data   = tx_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_q;
    assign bus.busy      = busy_q;
    assign bus.idle_flag = idle_q;
endmodule
